// File: rtl/reg_wb_multi_if.sv
// Bus bundle for the multi-port write-back register file: two write ports,
// scoreboard set, two bypassed read ports and the flat debug dump.
interface reg_wb_multi_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_REGS = 8,
    parameter int unsigned ADDR_W = 3
);
    logic                     WA_EN;
    logic [ADDR_W-1:0]        WA_ADDR;
    logic [DATA_W-1:0]        WA_DATA;
    logic                     WB_EN;
    logic [ADDR_W-1:0]        WB_ADDR;
    logic [DATA_W-1:0]        WB_DATA;
    logic                     SB_SET;
    logic [ADDR_W-1:0]        SB_ADDR;
    logic [ADDR_W-1:0]        RA_ADDR;
    logic [DATA_W-1:0]        RA_DATA;
    logic                     RA_BUSY;
    logic [ADDR_W-1:0]        RB_ADDR;
    logic [DATA_W-1:0]        RB_DATA;
    logic                     RB_BUSY;
    logic [N_REGS*DATA_W-1:0] REG_FLAT;
    logic                     COLLISION;

    modport master (
        output WA_EN, WA_ADDR, WA_DATA,
        output WB_EN, WB_ADDR, WB_DATA,
        output SB_SET, SB_ADDR,
        output RA_ADDR, RB_ADDR,
        input  RA_DATA, RA_BUSY, RB_DATA, RB_BUSY,
        input  REG_FLAT, COLLISION
    );

    modport slave (
        input  WA_EN, WA_ADDR, WA_DATA,
        input  WB_EN, WB_ADDR, WB_DATA,
        input  SB_SET, SB_ADDR,
        input  RA_ADDR, RB_ADDR,
        output RA_DATA, RA_BUSY, RB_DATA, RB_BUSY,
        output REG_FLAT, COLLISION
    );
endinterface

// File: rtl/reg_wb_multi.sv
// Two-write-port register file with per-register busy scoreboard and two
// write-through bypassed read ports; port B (load return) wins same-register writes.
module reg_wb_multi #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_REGS   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic          CLK_WB,
    input  logic          RESET_N,
    reg_wb_multi_if.slave bus
);

    localparam int unsigned N_RD = 2;

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic [N_REGS-1:0] r_busy;
    logic              r_collision;

    logic              w_wa_ok;
    logic              w_wb_ok;
    logic              w_sb_ok;
    logic              w_collision;
    logic [N_REGS-1:0] w_wa_hit;
    logic [N_REGS-1:0] w_wb_hit;
    logic [N_REGS-1:0] w_sb_hit;

    logic [ADDR_W-1:0] w_rd_addr [N_RD];
    logic [DATA_W-1:0] w_rd_data [N_RD];
    logic [N_RD-1:0]   w_rd_busy;

    // Address names a real, writable register (excludes hardwired r0).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < N_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_wa_ok     = bus.WA_EN  && addr_ok(bus.WA_ADDR);
    assign w_wb_ok     = bus.WB_EN  && addr_ok(bus.WB_ADDR);
    assign w_sb_ok     = bus.SB_SET && addr_ok(bus.SB_ADDR);
    assign w_collision = w_wa_ok && w_wb_ok && (bus.WA_ADDR == bus.WB_ADDR);

    // One-hot per-register decode of both write ports and the scoreboard set.
    always_comb begin
        w_wa_hit = '0;
        w_wb_hit = '0;
        w_sb_hit = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            w_wa_hit[i] = w_wa_ok && (bus.WA_ADDR == ADDR_W'(i));
            w_wb_hit[i] = w_wb_ok && (bus.WB_ADDR == ADDR_W'(i));
            w_sb_hit[i] = w_sb_ok && (bus.SB_ADDR == ADDR_W'(i));
        end
    end

    always_ff @(posedge CLK_WB) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                r_regs[i] <= '0;
            end
            r_busy      <= '0;
            r_collision <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                if (w_wb_hit[i]) begin
                    r_regs[i] <= bus.WB_DATA;
                end else if (w_wa_hit[i]) begin
                    r_regs[i] <= bus.WA_DATA;
                end
            end
            // A new producer issued this cycle outranks the write that retires the old one.
            r_busy      <= w_sb_hit | (r_busy & ~(w_wa_hit | w_wb_hit));
            r_collision <= w_collision;
        end
    end

    assign w_rd_addr[0] = bus.RA_ADDR;
    assign w_rd_addr[1] = bus.RB_ADDR;

    // Bypassed reads: in-flight write data is visible in the same cycle.
    always_comb begin
        for (int p = 0; p < int'(N_RD); p++) begin
            w_rd_data[p] = '0;
            w_rd_busy[p] = 1'b0;
            for (int i = 0; i < int'(N_REGS); i++) begin
                if (addr_ok(w_rd_addr[p]) && (w_rd_addr[p] == ADDR_W'(i))) begin
                    w_rd_data[p] = w_wb_hit[i] ? bus.WB_DATA :
                                   (w_wa_hit[i] ? bus.WA_DATA : r_regs[i]);
                    w_rd_busy[p] = r_busy[i] && !w_wa_hit[i] && !w_wb_hit[i];
                end
            end
        end
    end

    assign bus.RA_DATA   = w_rd_data[0];
    assign bus.RA_BUSY   = w_rd_busy[0];
    assign bus.RB_DATA   = w_rd_data[1];
    assign bus.RB_BUSY   = w_rd_busy[1];
    assign bus.COLLISION = r_collision;

    for (genvar g = 0; g < int'(N_REGS); g++) begin : g_flat
        assign bus.REG_FLAT[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: tb/tb_reg_wb_multi.sv
// Drives two register-file instances (8 regs plain, 6 regs with hardwired r0)
// with the same stimulus and compares both against an array-based reference model.
module tb_reg_wb_multi;

    logic clk;
    logic rst_n;

    reg_wb_multi_if #(.DATA_W(16), .N_REGS(8), .ADDR_W(3)) if0 ();
    reg_wb_multi_if #(.DATA_W(16), .N_REGS(6), .ADDR_W(3)) if1 ();

    reg_wb_multi #(.DATA_W(16), .N_REGS(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .CLK_WB(clk), .RESET_N(rst_n), .bus(if0.slave));
    reg_wb_multi #(.DATA_W(16), .N_REGS(6), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .CLK_WB(clk), .RESET_N(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        wa_en;
        logic [2:0]  wa_addr;
        logic [15:0] wa_data;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        sb_set;
        logic [2:0]  sb_addr;
        logic [2:0]  ra;
        logic [2:0]  rb;
    } stim_t;

    int n_checks;
    int n_fail;

    // Reference state for both instances.
    logic [15:0] m_regs [2][8];
    logic        m_busy [2][8];
    logic        m_coll [2];
    int          m_n    [2];
    bit          m_z    [2];

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ok(input int m, input logic [2:0] a);
        return (int'(a) < m_n[m]) && !(m_z[m] && (a == 3'd0));
    endfunction

    function automatic logic [15:0] m_read(input int m, input stim_t s, input logic [2:0] a);
        if (!m_ok(m, a)) return 16'h0;
        if (s.wb_en && s.wb_addr == a) return s.wb_data;
        if (s.wa_en && s.wa_addr == a) return s.wa_data;
        return m_regs[m][a];
    endfunction

    function automatic logic m_rbusy(input int m, input stim_t s, input logic [2:0] a);
        if (!m_ok(m, a)) return 1'b0;
        if ((s.wb_en && s.wb_addr == a) || (s.wa_en && s.wa_addr == a)) return 1'b0;
        return m_busy[m][a];
    endfunction

    task automatic m_step(input int m, input stim_t s);
        bit wa_w;
        bit wb_w;
        if (s.rst) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[m][i] = 16'h0;
                m_busy[m][i] = 1'b0;
            end
            m_coll[m] = 1'b0;
        end else begin
            wa_w = s.wa_en && m_ok(m, s.wa_addr);
            wb_w = s.wb_en && m_ok(m, s.wb_addr);
            m_coll[m] = wa_w && wb_w && (s.wa_addr == s.wb_addr);
            if (wa_w) begin
                m_regs[m][s.wa_addr] = s.wa_data;
                m_busy[m][s.wa_addr] = 1'b0;
            end
            if (wb_w) begin
                m_regs[m][s.wb_addr] = s.wb_data;
                m_busy[m][s.wb_addr] = 1'b0;
            end
            if (s.sb_set && m_ok(m, s.sb_addr)) m_busy[m][s.sb_addr] = 1'b1;
        end
    endtask

    function automatic stim_t mk();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // One clock: drive at posedge+1, check reads mid-cycle, check state at next posedge+1.
    task automatic do_cycle(input stim_t s);
        logic [15:0]  ra_d, rb_d;
        logic         ra_b, rb_b, coll;
        logic [127:0] flat;
        rst_n       = !s.rst;
        if0.WA_EN   = s.wa_en;   if1.WA_EN   = s.wa_en;
        if0.WA_ADDR = s.wa_addr; if1.WA_ADDR = s.wa_addr;
        if0.WA_DATA = s.wa_data; if1.WA_DATA = s.wa_data;
        if0.WB_EN   = s.wb_en;   if1.WB_EN   = s.wb_en;
        if0.WB_ADDR = s.wb_addr; if1.WB_ADDR = s.wb_addr;
        if0.WB_DATA = s.wb_data; if1.WB_DATA = s.wb_data;
        if0.SB_SET  = s.sb_set;  if1.SB_SET  = s.sb_set;
        if0.SB_ADDR = s.sb_addr; if1.SB_ADDR = s.sb_addr;
        if0.RA_ADDR = s.ra;      if1.RA_ADDR = s.ra;
        if0.RB_ADDR = s.rb;      if1.RB_ADDR = s.rb;
        #2;
        if (!s.rst) begin
            for (int m = 0; m < 2; m++) begin
                if (m == 0) begin
                    ra_d = if0.RA_DATA; ra_b = if0.RA_BUSY; rb_d = if0.RB_DATA; rb_b = if0.RB_BUSY;
                end else begin
                    ra_d = if1.RA_DATA; ra_b = if1.RA_BUSY; rb_d = if1.RB_DATA; rb_b = if1.RB_BUSY;
                end
                check_val($sformatf("d%0d_ra_data@%0d", m, s.ra), 128'(ra_d), 128'(m_read(m, s, s.ra)));
                check_val($sformatf("d%0d_ra_busy@%0d", m, s.ra), 128'(ra_b), 128'(m_rbusy(m, s, s.ra)));
                check_val($sformatf("d%0d_rb_data@%0d", m, s.rb), 128'(rb_d), 128'(m_read(m, s, s.rb)));
                check_val($sformatf("d%0d_rb_busy@%0d", m, s.rb), 128'(rb_b), 128'(m_rbusy(m, s, s.rb)));
            end
        end
        m_step(0, s);
        m_step(1, s);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                flat = if0.REG_FLAT; coll = if0.COLLISION;
            end else begin
                flat = 128'(if1.REG_FLAT); coll = if1.COLLISION;
            end
            for (int i = 0; i < m_n[m]; i++) begin
                check_val($sformatf("d%0d_r%0d", m, i), 128'(flat[i*16 +: 16]), 128'(m_regs[m][i]));
            end
            check_val($sformatf("d%0d_collision", m), 128'(coll), 128'(m_coll[m]));
        end
    endtask

    initial begin
        stim_t s;
        n_checks = 0;
        n_fail   = 0;
        m_n[0] = 8; m_z[0] = 1'b0;
        m_n[1] = 6; m_z[1] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset must override a simultaneous write.
        s = mk(); s.rst = 1'b1; s.wa_en = 1'b1; s.wa_addr = 3'd3; s.wa_data = 16'hBEEF;
        do_cycle(s);
        check_val("t1_flat0_zero", if0.REG_FLAT, 128'h0);
        check_val("t1_coll0_zero", 128'(if0.COLLISION), 128'h0);

        // Distinct-address dual write.
        s = mk(); s.wa_en = 1'b1; s.wa_addr = 3'd2; s.wa_data = 16'h1111;
        s.wb_en = 1'b1; s.wb_addr = 3'd5; s.wb_data = 16'h2222;
        do_cycle(s);
        check_val("t2_r2", 128'(if0.REG_FLAT[2*16 +: 16]), 128'h1111);
        check_val("t2_r5", 128'(if0.REG_FLAT[5*16 +: 16]), 128'h2222);

        // Same-address dual write: B wins and a one-cycle collision pulse.
        s = mk(); s.wa_en = 1'b1; s.wa_addr = 3'd4; s.wa_data = 16'hAAAA;
        s.wb_en = 1'b1; s.wb_addr = 3'd4; s.wb_data = 16'h5555;
        do_cycle(s);
        check_val("t3_r4", 128'(if0.REG_FLAT[4*16 +: 16]), 128'h5555);
        check_val("t3_coll_hi", 128'(if0.COLLISION), 128'h1);
        do_cycle(mk());
        check_val("t3_coll_lo", 128'(if0.COLLISION), 128'h0);

        // Scoreboard set, pending read, then retiring load with bypass.
        s = mk(); s.sb_set = 1'b1; s.sb_addr = 3'd6; s.ra = 3'd6;
        do_cycle(s);
        s = mk(); s.ra = 3'd6;
        do_cycle(s);
        s = mk(); s.ra = 3'd6; s.wb_en = 1'b1; s.wb_addr = 3'd6; s.wb_data = 16'h00C3;
        do_cycle(s);
        s = mk(); s.ra = 3'd6;
        do_cycle(s);

        // Set and clearing write to the same register: busy stays set.
        s = mk(); s.sb_set = 1'b1; s.sb_addr = 3'd1; s.wa_en = 1'b1; s.wa_addr = 3'd1; s.wa_data = 16'h0007;
        do_cycle(s);
        check_val("t5_r1", 128'(if0.REG_FLAT[1*16 +: 16]), 128'h0007);
        s = mk(); s.ra = 3'd1;
        do_cycle(s);

        // Hardwired r0 and out-of-range register on the 6-entry instance.
        s = mk(); s.wa_en = 1'b1; s.wa_addr = 3'd0; s.wa_data = 16'hFFFF;
        s.wb_en = 1'b1; s.wb_addr = 3'd7; s.wb_data = 16'h1234; s.ra = 3'd7; s.rb = 3'd0;
        do_cycle(s);
        check_val("t6_d1_r0", 128'(if1.REG_FLAT[0 +: 16]), 128'h0);
        s = mk(); s.sb_set = 1'b1; s.sb_addr = 3'd7; s.ra = 3'd7; s.rb = 3'd0;
        do_cycle(s);

        // Randomized traffic biased toward collisions and read-after-write hits.
        for (int n = 0; n < 400; n++) begin
            s = mk();
            s.rst     = ($urandom_range(0, 79) == 0);
            s.wa_en   = 1'($urandom_range(0, 1));
            s.wa_addr = 3'($urandom_range(0, 7));
            s.wa_data = 16'($urandom);
            s.wb_en   = 1'($urandom_range(0, 1));
            s.wb_addr = ($urandom_range(0, 3) == 0) ? s.wa_addr : 3'($urandom_range(0, 7));
            s.wb_data = 16'($urandom);
            s.sb_set  = 1'($urandom_range(0, 1));
            s.sb_addr = ($urandom_range(0, 3) == 0) ? s.wa_addr : 3'($urandom_range(0, 7));
            s.ra      = ($urandom_range(0, 2) == 0) ? s.wb_addr : 3'($urandom_range(0, 7));
            s.rb      = ($urandom_range(0, 2) == 0) ? s.sb_addr : 3'($urandom_range(0, 7));
            do_cycle(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
